// File: rtl/l2_cacheline_adaptor_if.sv
// ---------------------------------------------------------------------------
// l2_cacheline_adaptor_if
//
// Purpose: bundles the L2-side line handshake and the memory-side burst
// handshake of the cacheline adaptor into one interface.
//
// Signals (directions as seen by the adaptor, modport slave):
//   address_i  in   ADDR_WIDTH   L2 request address
//   read_i     in   1            line read request (level)
//   write_i    in   1            line write request (level)
//   line_i     in   LINE_WIDTH   line to write back
//   line_o     out  LINE_WIDTH   assembled read line
//   resp_o     out  1            one-cycle completion pulse to L2
//   address_o  out  ADDR_WIDTH   line-aligned burst address
//   read_o     out  1            burst read request to memory
//   write_o    out  1            burst write request to memory
//   burst_i    in   BURST_WIDTH  read beat from memory
//   burst_o    out  BURST_WIDTH  write beat to memory
//   resp_i     in   1            memory beat acknowledge
//
// Modports: slave = the adaptor; master = its environment (L2 controller
// plus burst memory), with every direction reversed.
// ---------------------------------------------------------------------------
interface l2_cacheline_adaptor_if #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
);
    logic [ADDR_WIDTH-1:0]  address_i;
    logic                   read_i;
    logic                   write_i;
    logic [LINE_WIDTH-1:0]  line_i;
    logic [LINE_WIDTH-1:0]  line_o;
    logic                   resp_o;
    logic [ADDR_WIDTH-1:0]  address_o;
    logic                   read_o;
    logic                   write_o;
    logic [BURST_WIDTH-1:0] burst_i;
    logic [BURST_WIDTH-1:0] burst_o;
    logic                   resp_i;

    modport slave (
        input  address_i, read_i, write_i, line_i, burst_i, resp_i,
        output line_o, resp_o, address_o, read_o, write_o, burst_o
    );

    modport master (
        output address_i, read_i, write_i, line_i, burst_i, resp_i,
        input  line_o, resp_o, address_o, read_o, write_o, burst_o
    );
endinterface

// File: rtl/l2_cacheline_adaptor.sv
// ---------------------------------------------------------------------------
// l2_cacheline_adaptor
//
// Purpose: turns whole-line L2 read/write requests into fixed-length bursts
// of BURSTS = LINE_WIDTH/BURST_WIDTH beats on a narrower memory port.
// A write latches the line and streams it out least-significant beat first;
// a read assembles incoming beats and publishes the full line on completion.
//
// Ports:
//   clk   in  1   clock, all state updates on the rising edge
//   rst   in  1   synchronous active-low reset
//   bus   l2_cacheline_adaptor_if.slave  (see interface header for signals)
// ---------------------------------------------------------------------------
module l2_cacheline_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    l2_cacheline_adaptor_if.slave  bus
);

    localparam int BURSTS = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W  = $clog2(BURSTS);
    localparam int OFFSET = $clog2(LINE_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Lines are kept as arrays of beats so the beat counter indexes them
    // directly; beat 0 is the least-significant slice.
    typedef logic [BURSTS-1:0][BURST_WIDTH-1:0] line_t;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [ADDR_WIDTH-1:0]  addr_q,  addr_d;
    line_t                  wline_q, wline_d;   // latched write-back line
    line_t                  asm_q,   asm_d;     // read beats in progress
    line_t                  line_q,  line_d;    // last completed read line

    logic                   last_beat;
    logic [ADDR_WIDTH-1:0]  aligned_addr;

    assign last_beat    = (count_q == CNT_W'(BURSTS - 1));
    assign aligned_addr = {bus.address_i[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the line registers are reset too, because line_o and
            // burst_o must read zero after reset rather than stale data.
            state_q <= IDLE;
            count_q <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            asm_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            asm_q   <= asm_d;
            line_q  <= line_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    // NOTE: every variable gets a hold-value default before the case, so
    // no path through the block leaves one unassigned and no latch forms.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        asm_d   = asm_q;
        line_d  = line_q;

        unique case (state_q)
            IDLE: begin
                count_d = '0;
                // Write has priority: a dirty victim must reach memory
                // before the refill read that follows it.
                if (bus.write_i) begin
                    state_d = WRITE;
                    addr_d  = aligned_addr;
                    wline_d = bus.line_i;
                end else if (bus.read_i) begin
                    state_d = READ;
                    addr_d  = aligned_addr;
                end
            end

            READ: begin
                if (bus.resp_i) begin
                    asm_d[count_q] = bus.burst_i;
                    count_d        = count_q + CNT_W'(1);
                    if (last_beat) begin
                        state_d = DONE;
                        // Publish including the beat arriving this cycle,
                        // so line_o is valid in the same cycle as resp_o.
                        line_d  = asm_d;
                    end
                end
            end

            WRITE: begin
                if (bus.resp_i) begin
                    count_d = count_q + CNT_W'(1);
                    if (last_beat) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.read_o  = (state_q == READ);
        bus.write_o = (state_q == WRITE);
        bus.resp_o  = (state_q == DONE);
        bus.burst_o = '0;
        if (state_q == WRITE) begin
            bus.burst_o = wline_q[count_q];
        end
    end

    assign bus.address_o = addr_q;
    assign bus.line_o    = line_q;

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// ---------------------------------------------------------------------------
// tb_l2_cacheline_adaptor
//
// Self-checking bench for l2_cacheline_adaptor. Inputs are driven and
// outputs sampled on the falling edge. Expected values come from a
// transaction-level model: a read's line is the concatenation of the beats
// supplied, a write's beats are the slices of the line offered, and the
// published line only changes when a read completes or reset is applied.
// ---------------------------------------------------------------------------
module tb_l2_cacheline_adaptor;

    localparam int LW = 256;
    localparam int BW = 64;
    localparam int AW = 32;
    localparam int NB = LW / BW;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    l2_cacheline_adaptor_if #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

    l2_cacheline_adaptor #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [LW-1:0] exp_line;           // model of line_o
    logic [BW-1:0] rd_beats [NB];      // beats the memory returns next read

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return a - (a % AW'(LW / 8));
    endfunction

    function automatic logic [BW-1:0] rand_beat();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic fill_random_beats();
        for (int k = 0; k < NB; k++) rd_beats[k] = rand_beat();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_idle_read_o"},  bus.read_o,  1'b0);
        check({tag, "_idle_write_o"}, bus.write_o, 1'b0);
        check({tag, "_idle_resp_o"},  bus.resp_o,  1'b0);
    endtask

    // gap < 0 picks a random 0..3 stall before each beat.
    function automatic int pick_gap(input int gap);
        return (gap < 0) ? int'($urandom_range(3, 0)) : gap;
    endfunction

    // Whole read transaction; starts and ends on a negedge with the DUT idle.
    task automatic run_read(input string tag, input logic [AW-1:0] addr, input int gap);
        logic [LW-1:0] new_line;
        check_idle(tag);
        bus.address_i = addr;
        bus.read_i    = 1'b1;
        bus.write_i   = 1'b0;
        step();
        for (int k = 0; k < NB; k++) begin
            for (int g = pick_gap(gap); g > 0; g--) begin
                bus.resp_i  = 1'b0;
                bus.burst_i = rand_beat();
                check({tag, "_stall_read_o"}, bus.read_o, 1'b1);
                check({tag, "_stall_resp_o"}, bus.resp_o, 1'b0);
                check({tag, "_stall_line_o"}, bus.line_o, exp_line);
                step();
            end
            check({tag, "_beat_read_o"},    bus.read_o,    1'b1);
            check({tag, "_beat_write_o"},   bus.write_o,   1'b0);
            check({tag, "_beat_resp_o"},    bus.resp_o,    1'b0);
            check({tag, "_beat_address_o"}, bus.address_o, align(addr));
            check({tag, "_beat_line_o"},    bus.line_o,    exp_line);
            bus.resp_i  = 1'b1;
            bus.burst_i = rd_beats[k];
            step();
        end
        bus.resp_i = 1'b0;
        for (int k = 0; k < NB; k++) new_line[k*BW +: BW] = rd_beats[k];
        exp_line = new_line;
        check({tag, "_done_resp_o"}, bus.resp_o, 1'b1);
        check({tag, "_done_read_o"}, bus.read_o, 1'b0);
        check({tag, "_done_line_o"}, bus.line_o, exp_line);
        bus.read_i = 1'b0;
        step();
        check({tag, "_after_resp_o"}, bus.resp_o, 1'b0);
    endtask

    // Whole write transaction. With hold_read, read_i stays high through
    // and after the write to model a write-back followed by an allocate.
    task automatic run_write(input string tag, input logic [AW-1:0] addr,
                             input logic [LW-1:0] line, input int gap, input bit hold_read);
        check_idle(tag);
        bus.address_i = addr;
        bus.line_i    = line;
        bus.write_i   = 1'b1;
        bus.read_i    = hold_read;
        step();
        bus.line_i = rand_line();   // the latched copy must be used
        for (int k = 0; k < NB; k++) begin
            for (int g = pick_gap(gap); g > 0; g--) begin
                bus.resp_i = 1'b0;
                check({tag, "_stall_write_o"}, bus.write_o, 1'b1);
                check({tag, "_stall_burst_o"}, bus.burst_o, line[k*BW +: BW]);
                step();
            end
            check({tag, "_beat_write_o"},   bus.write_o,   1'b1);
            check({tag, "_beat_read_o"},    bus.read_o,    1'b0);
            check({tag, "_beat_resp_o"},    bus.resp_o,    1'b0);
            check({tag, "_beat_address_o"}, bus.address_o, align(addr));
            check({tag, "_beat_burst_o"},   bus.burst_o,   line[k*BW +: BW]);
            bus.resp_i = 1'b1;
            step();
        end
        bus.resp_i = 1'b0;
        check({tag, "_done_resp_o"},  bus.resp_o,  1'b1);
        check({tag, "_done_write_o"}, bus.write_o, 1'b0);
        check({tag, "_done_line_o"},  bus.line_o,  exp_line);
        bus.write_i = 1'b0;
        step();
        check({tag, "_after_resp_o"}, bus.resp_o, 1'b0);
    endtask

    initial begin
        logic [LW-1:0] wl;
        logic [LW-1:0] dir_line;

        bus.address_i = '0;
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.line_i    = '0;
        bus.burst_i   = '0;
        bus.resp_i    = 1'b0;
        exp_line      = '0;

        // Reset state
        step();
        step();
        check("rst_read_o",    bus.read_o,    1'b0);
        check("rst_write_o",   bus.write_o,   1'b0);
        check("rst_resp_o",    bus.resp_o,    1'b0);
        check("rst_address_o", bus.address_o, '0);
        check("rst_burst_o",   bus.burst_o,   '0);
        check("rst_line_o",    bus.line_o,    '0);
        rst = 1'b1;
        step();

        // Directed read, consecutive acks
        rd_beats[0] = 64'h1111_1111_1111_1111;
        rd_beats[1] = 64'h2222_2222_2222_2222;
        rd_beats[2] = 64'h3333_3333_3333_3333;
        rd_beats[3] = 64'h4444_4444_4444_4444;
        dir_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        run_read("rd_dir", 32'h1234_5678, 0);
        check("rd_dir_line_const", bus.line_o, dir_line);
        check("rd_dir_addr_const", bus.address_o, 32'h1234_5660);

        // Directed write, consecutive acks
        wl = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
              64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
        run_write("wr_dir", 32'h0000_ABFF, wl, 0, 1'b0);

        // Stalled read: 2-cycle gaps, same beats, same assembled line
        run_read("rd_stall", 32'h8000_0041, 2);
        check("rd_stall_line_const", bus.line_o, dir_line);

        // Write-back then allocate
        fill_random_beats();
        run_write("wb", 32'hCAFE_0020, rand_line(), 1, 1'b1);
        run_read("alloc", 32'hCAFE_0020, 1);

        // Reset mid-read after two beats
        fill_random_beats();
        check_idle("rst_mid");
        bus.address_i = 32'h5555_5555;
        bus.read_i    = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = rd_beats[k];
            step();
        end
        rst         = 1'b0;
        bus.burst_i = rd_beats[2];
        step();
        exp_line = '0;
        check("rst_mid_read_o",    bus.read_o,    1'b0);
        check("rst_mid_resp_o",    bus.resp_o,    1'b0);
        check("rst_mid_line_o",    bus.line_o,    '0);
        check("rst_mid_address_o", bus.address_o, '0);
        check("rst_mid_burst_o",   bus.burst_o,   '0);
        rst        = 1'b1;
        bus.read_i = 1'b0;
        bus.resp_i = 1'b0;
        step();
        check("rst_mid_after_resp_o", bus.resp_o, 1'b0);
        check("rst_mid_after_line_o", bus.line_o, '0);
        fill_random_beats();
        run_read("rd_after_rst", 32'h0BAD_F00D, 0);

        // Spurious acks while idle change nothing
        for (int i = 0; i < 3; i++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = rand_beat();
            step();
            check("spur_read_o",  bus.read_o,  1'b0);
            check("spur_write_o", bus.write_o, 1'b0);
            check("spur_resp_o",  bus.resp_o,  1'b0);
            check("spur_line_o",  bus.line_o,  exp_line);
        end
        bus.resp_i = 1'b0;
        step();
        fill_random_beats();
        run_read("rd_after_spur", 32'h7777_7777, 0);

        // Randomized mix of transactions with random stalls
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(1, 0) == 1) begin
                fill_random_beats();
                run_read("rnd_rd", $urandom, -1);
            end else begin
                run_write("rnd_wr", $urandom, rand_line(), -1, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
